// File: rtl/keypad_emulator.sv
// Far-end 4x4 keypad model: replays queued key codes as timed presses on the row
// return lines in response to the scanner's active-low column drive.
module keypad_emulator #(
  parameter int PRESS_CYCLES   = 1000000,
  parameter int RELEASE_CYCLES = 1000000,
  parameter int FIFO_DEPTH     = 4,
  parameter int CNT_W          = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic       abort,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       busy,
  output logic       pressed,
  output logic       key_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] PRESS_LOAD   = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LOAD = CNT_W'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS, RELEASE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       cur_code_q;
  logic [3:0]       row_q, row_d;
  logic             pressed_q, pressed_d;
  logic             key_done_q, key_done_d;
  logic             empty, full, push, pop, cnt_zero;

  // The extra pointer MSB separates a full FIFO from an empty one.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign key_ready = !full && !abort;
  assign push      = key_valid && key_ready;
  assign pop       = (state_q == IDLE) && !empty && !abort;
  assign busy      = (state_q != IDLE) || !empty;
  assign cnt_zero  = (cnt_q == '0);

  assign row      = row_q;
  assign pressed  = pressed_q;
  assign key_done = key_done_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      row_q      <= 4'hF;
      pressed_q  <= 1'b0;
      key_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      row_q      <= row_d;
      pressed_q  <= pressed_d;
      key_done_q <= key_done_d;
    end
  end

  // Key storage carries no reset; it is only read behind the FIFO/state qualifiers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= key_code;
    if (pop)  cur_code_q <= mem_q[rd_ptr_q[AW-1:0]];
  end

  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!empty) state_d = PRESS;
        PRESS:   if (cnt_zero) state_d = RELEASE;
        RELEASE: if (cnt_zero) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
    key_done_d = 1'b0;
    if (abort) begin
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE:    if (pop) cnt_d = PRESS_LOAD;
        PRESS:   cnt_d = cnt_zero ? RELEASE_LOAD : cnt_q - 1'b1;
        RELEASE: begin
          cnt_d      = cnt_zero ? '0 : cnt_q - 1'b1;
          key_done_d = cnt_zero;
        end
        default: cnt_d = '0;
      endcase
    end
    pressed_d = (state_d == PRESS);
    // Only the pressed key's column matters; any other low columns are ignored.
    row_d = 4'hF;
    if (state_q == PRESS && !col[cur_code_q[1:0]]) row_d[cur_code_q[3:2]] = 1'b0;
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed scenarios plus random traffic,
// compared each cycle against a queue-and-elapsed-time model of a keypad replay.
module tb_keypad_emulator;

  localparam int P = 4;
  localparam int R = 3;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_code = '0;
  logic       key_valid = 1'b0;
  logic       key_ready;
  logic       abort = 1'b0;
  logic [3:0] col = 4'hF;
  logic [3:0] row;
  logic       busy, pressed, key_done;
  logic [7:0] obs;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  keypad_emulator #(.PRESS_CYCLES(P), .RELEASE_CYCLES(R), .FIFO_DEPTH(D), .CNT_W(24)) dut (
    .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .abort(abort), .col(col), .row(row),
    .busy(busy), .pressed(pressed), .key_done(key_done)
  );

  always #5 clk = ~clk;
  assign obs = {row, pressed, key_done, busy, key_ready};

  // Reference: queued codes; an active key lasts P+R cycles measured from its pop.
  logic [3:0] mq[$];
  logic       m_active;
  int         m_el;
  logic [3:0] m_code;
  logic       m_done;
  logic [3:0] m_row;

  function automatic void model_reset();
    mq.delete();
    m_active = 1'b0;
    m_el     = 0;
    m_code   = '0;
    m_done   = 1'b0;
    m_row    = 4'hF;
  endfunction

  function automatic logic [7:0] exp_vec();
    return {m_row, m_active && (m_el < P), m_done,
            m_active || (mq.size() > 0), (mq.size() < D) && !abort};
  endfunction

  task automatic model_step();
    int   sz0;
    logic was_pressing;
    if (rst) begin
      model_reset();
      return;
    end
    sz0          = mq.size();
    was_pressing = m_active && (m_el < P);
    m_row        = 4'hF;
    if (was_pressing && !col[m_code[1:0]]) m_row[m_code[3:2]] = 1'b0;
    m_done = 1'b0;
    if (abort) begin
      mq.delete();
      m_active = 1'b0;
    end else begin
      if (m_active) begin
        m_el++;
        if (m_el == P + R) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end else if (sz0 > 0) begin
        m_code   = mq.pop_front();
        m_active = 1'b1;
        m_el     = 0;
      end
      if (key_valid && sz0 < D) mq.push_back(key_code);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    vectors++;
    if (obs !== {4'hF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset: got row/pr/done/busy/rdy=%b want %b", obs, {4'hF, 4'b0001});
    end
    tick();
    vectors++;
    if (obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL reset_idle cyc%0d: got %b want %b", cyc, obs, exp_vec());
    end
  endtask

  task automatic test_single_press();
    int npress = 0, ndone = 0, first_off = -1, done_at = -1;
    col = 4'b1011; key_code = 4'h6; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL single cyc%0d: got %b want %b", cyc, obs, exp_vec());
      end
      if (pressed) npress++;
      else if (npress > 0 && first_off < 0) first_off = i;
      if (key_done) begin ndone++; done_at = i; end
      tick();
    end
    vectors++;
    if (npress !== P || ndone !== 1 || (done_at - first_off) !== R) begin
      miscompares++;
      $display("FAIL single_timing: got press=%0d done=%0d gap=%0d want %0d 1 %0d",
               npress, ndone, done_at - first_off, P, R);
    end
  endtask

  task automatic test_col_toggle();
    key_code = 4'h6; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      col = (i % 2 == 0) ? 4'b1110 : 4'b1011;
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL col_toggle cyc%0d: got %b want %b", cyc, obs, exp_vec());
      end
    end
    col = 4'h0; key_code = 4'h6; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL col_all_low cyc%0d: got %b want %b", cyc, obs, exp_vec());
      end
      if (pressed && dut.pressed && i >= 2 && row !== 4'b1101) begin
        miscompares++;
        $display("FAIL col_all_low_row cyc%0d: got %b want 1101", cyc, row);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int ndone = 0, last_done = -1, bad_gap = 0;
    col = 4'h0;
    for (int k = 1; k <= 5; k++) begin
      key_code = 4'(k); key_valid = 1'b1;
      tick();
    end
    key_valid = 1'b0;
    vectors++;
    if (key_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_full_ready: got %b want 0", key_ready);
    end
    for (int i = 0; i < 60; i++) begin
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL b2b cyc%0d: got %b want %b", cyc, obs, exp_vec());
      end
      if (key_done) begin
        if (last_done >= 0 && (i - last_done) != P + R + 1) bad_gap++;
        last_done = i;
        ndone++;
      end
      tick();
    end
    vectors++;
    if (ndone !== 5 || bad_gap !== 0) begin
      miscompares++;
      $display("FAIL b2b_done: got %0d pulses %0d bad gaps want 5 pulses 0 bad gaps",
               ndone, bad_gap);
    end
  endtask

  task automatic test_abort();
    int nbad = 0;
    col = 4'h0; key_valid = 1'b1;
    key_code = 4'h9; tick();
    key_code = 4'hA; tick();
    key_code = 4'hB; tick();
    key_valid = 1'b0; abort = 1'b1;
    #1;
    vectors++;
    if (obs !== exp_vec() || pressed !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_setup cyc%0d: got %b want %b", cyc, obs, exp_vec());
    end
    tick();
    abort = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || key_done !== 1'b0 || obs !== exp_vec()) begin
      miscompares++;
      $display("FAIL abort_flush cyc%0d: got %b want %b", cyc, obs, exp_vec());
    end
    tick();
    vectors++;
    if (row !== 4'hF) begin
      miscompares++;
      $display("FAIL abort_row: got %b want 1111", row);
    end
    for (int i = 0; i < 20; i++) begin
      if (pressed || key_done || busy) nbad++;
      tick();
    end
    vectors++;
    if (nbad !== 0) begin
      miscompares++;
      $display("FAIL abort_quiet: got %0d active cycles want 0", nbad);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    col = 4'h0; key_code = 4'h6; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    while (!pressed && guard < 20) begin tick(); guard++; end
    tick();
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (row !== 4'hF || pressed !== 1'b0 || busy !== 1'b0 || key_done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst: got row=%b pr=%b busy=%b done=%b want 1111 0 0 0",
               row, pressed, busy, key_done);
    end
    model_reset();
    tick();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || key_ready !== 1'b1 || pressed !== 1'b0) begin
      miscompares++;
      $display("FAIL async_rst_release: got busy=%b rdy=%b pr=%b want 0 1 0",
               busy, key_ready, pressed);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL async_rst_idle cyc%0d: got %b want %b", cyc, obs, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      key_valid = ($urandom_range(0, 2) == 0);
      key_code  = 4'($urandom_range(0, 15));
      col       = 4'($urandom_range(0, 15));
      abort     = ($urandom_range(0, 59) == 0);
      #1;
      vectors++;
      if (obs !== exp_vec()) begin
        miscompares++;
        $display("FAIL random cyc%0d: got %b want %b", cyc, obs, exp_vec());
      end
      tick();
    end
    key_valid = 1'b0;
    abort     = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_col_toggle();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
